fpu_psc_pipe: RTL and testbench



---
 rtl/fpu_psc_pkg.sv | 94 +++++++++
 rtl/fpu_psc_classify.sv | 30 +++
 rtl/fpu_psc_pipe.sv | 139 +++++++++++++
 tb/tb_fpu_psc_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_psc_pkg.sv
// Shared types and decision logic for the FPU special-case classifier.
package fpu_psc_pkg;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_e;

    typedef enum logic [2:0] {
        SEL_NORMAL = 3'b000,
        SEL_ZERO   = 3'b001,
        SEL_INF    = 3'b010,
        SEL_QNAN   = 3'b011,
        SEL_PASS_A = 3'b100,
        SEL_PASS_B = 3'b101
    } sel_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'b00,
        CLS_NORM = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } cls_e;

    typedef struct packed {
        sel_e sel;
        logic sign;
    } dec_t;

    localparam int SEL_W = 3;

    // The reserved opcode 2'b11 behaves as MUL.
    function automatic op_e decode_op(input logic [1:0] code);
        case (code)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_MUL;
        endcase
    endfunction

    // True when a qNaN is manufactured from non-NaN operands.
    function automatic logic psc_invalid(input op_e op, input cls_e ca, input cls_e cb,
                                         input logic sa, input logic sb);
        logic sb_eff;
        logic any_nan;
        sb_eff  = sb ^ (op == OP_SUB);
        any_nan = (ca == CLS_NAN) || (cb == CLS_NAN);
        if (any_nan)
            return 1'b0;
        if (op == OP_MUL)
            return ((ca == CLS_INF) && (cb == CLS_ZERO)) || ((ca == CLS_ZERO) && (cb == CLS_INF));
        return (ca == CLS_INF) && (cb == CLS_INF) && (sa != sb_eff);
    endfunction

    function automatic dec_t psc_decide(input op_e op, input cls_e ca, input cls_e cb,
                                        input logic sa, input logic sb);
        dec_t d;
        logic sb_eff;
        logic any_nan;
        sb_eff  = sb ^ (op == OP_SUB);
        any_nan = (ca == CLS_NAN) || (cb == CLS_NAN);
        d.sel   = SEL_NORMAL;
        d.sign  = 1'b0;
        if (any_nan || psc_invalid(op, ca, cb, sa, sb)) begin
            d.sel = SEL_QNAN;
        end else if (op == OP_MUL) begin
            d.sign = sa ^ sb;
            if ((ca == CLS_INF) || (cb == CLS_INF))
                d.sel = SEL_INF;
            else if ((ca == CLS_ZERO) || (cb == CLS_ZERO))
                d.sel = SEL_ZERO;
        end else begin
            if (ca == CLS_INF) begin
                d.sel  = SEL_INF;
                d.sign = sa;
            end else if (cb == CLS_INF) begin
                d.sel  = SEL_INF;
                d.sign = sb_eff;
            end else if ((ca == CLS_ZERO) && (cb == CLS_ZERO)) begin
                d.sel  = SEL_ZERO;
                d.sign = sa & sb_eff;
            end else if (cb == CLS_ZERO) begin
                d.sel  = SEL_PASS_A;
                d.sign = sa;
            end else if (ca == CLS_ZERO) begin
                d.sel  = SEL_PASS_B;
                d.sign = sb_eff;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/fpu_psc_classify.sv
// Combinational operand classifier; denormals flush to ZERO.
module fpu_psc_classify
    import fpu_psc_pkg::*;
#(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24
) (
    input  logic [SIZE_EXP-1:0] exp_val,
    input  logic [SIZE_MAN-1:0] man_val,
    output cls_e                cls
);

    logic exp_max;
    logic frac_nz;
    logic unused_hidden;

    assign exp_max       = &exp_val;
    assign frac_nz       = |man_val[SIZE_MAN-2:0];
    assign unused_hidden = man_val[SIZE_MAN-1];

    // Classify from exponent and fraction alone; the hidden bit carries no information.
    always_comb begin
        cls = CLS_NORM;
        if (exp_val == '0)
            cls = CLS_ZERO;
        else if (exp_max)
            cls = frac_nz ? CLS_NAN : CLS_INF;
    end

endmodule

// File: rtl/fpu_psc_pipe.sv
// Two-stage special-case classifier: S1 holds classes, S2 holds the override decision.
module fpu_psc_pipe
    import fpu_psc_pkg::*;
#(
    parameter int SIZE_EXP = 8,
    parameter int SIZE_MAN = 24,
    parameter int TAG_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_op,
    input  logic                i_sign_a,
    input  logic                i_sign_b,
    input  logic [SIZE_EXP-1:0] i_exp_a,
    input  logic [SIZE_EXP-1:0] i_exp_b,
    input  logic [SIZE_MAN-1:0] i_man_a,
    input  logic [SIZE_MAN-1:0] i_man_b,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_sign,
    output logic [TAG_W-1:0]    o_tag,
    input  logic                i_clr,
    output logic                o_flag_invalid,
    output logic                o_flag_nan_in,
    output logic [CNT_W-1:0]    o_special_cnt
);

    cls_e             cls_a, cls_b;
    op_e              op_in;
    logic             in_xfer, out_xfer, s2_load;

    logic             s1_vld;
    op_e              s1_op;
    cls_e             s1_cls_a, s1_cls_b;
    logic             s1_sa, s1_sb;
    logic [TAG_W-1:0] s1_tag;
    dec_t             s1_dec;

    logic             s2_vld;
    sel_e             s2_sel;
    logic             s2_sign;
    logic [TAG_W-1:0] s2_tag;

    fpu_psc_classify #(.SIZE_EXP(SIZE_EXP), .SIZE_MAN(SIZE_MAN)) u_cls_a (
        .exp_val (i_exp_a),
        .man_val (i_man_a),
        .cls     (cls_a)
    );

    fpu_psc_classify #(.SIZE_EXP(SIZE_EXP), .SIZE_MAN(SIZE_MAN)) u_cls_b (
        .exp_val (i_exp_b),
        .man_val (i_man_b),
        .cls     (cls_b)
    );

    assign op_in    = decode_op(i_op);
    assign s2_load  = ~s2_vld | i_ready;
    assign o_ready  = ~s1_vld | ~s2_vld | i_ready;
    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = s2_vld & i_ready;
    assign s1_dec   = psc_decide(s1_op, s1_cls_a, s1_cls_b, s1_sa, s1_sb);

    assign o_valid  = s2_vld;
    assign o_sel    = s2_sel;
    assign o_sign   = s2_sign;
    assign o_tag    = s2_tag;

    // Stage 1: capture operand classes; a hole is written whenever the slot frees with no input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld   <= 1'b0;
            s1_op    <= OP_MUL;
            s1_cls_a <= CLS_ZERO;
            s1_cls_b <= CLS_ZERO;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_tag   <= '0;
        end else if (o_ready) begin
            s1_vld <= i_valid;
            if (i_valid) begin
                s1_op    <= op_in;
                s1_cls_a <= cls_a;
                s1_cls_b <= cls_b;
                s1_sa    <= i_sign_a;
                s1_sb    <= i_sign_b;
                s1_tag   <= i_tag;
            end
        end
    end

    // Stage 2: register the override decision; held while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld  <= 1'b0;
            s2_sel  <= SEL_NORMAL;
            s2_sign <= 1'b0;
            s2_tag  <= '0;
        end else if (s2_load) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sel  <= s1_dec.sel;
                s2_sign <= s1_dec.sign;
                s2_tag  <= s1_tag;
            end
        end
    end

    // Sticky flags set on input acceptance; clear wins over a same-cycle set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_flag_invalid <= 1'b0;
            o_flag_nan_in  <= 1'b0;
        end else if (i_clr) begin
            o_flag_invalid <= 1'b0;
            o_flag_nan_in  <= 1'b0;
        end else if (in_xfer) begin
            if (psc_invalid(op_in, cls_a, cls_b, i_sign_a, i_sign_b))
                o_flag_invalid <= 1'b1;
            if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN))
                o_flag_nan_in <= 1'b1;
        end
    end

    // Saturating count of delivered overrides; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_special_cnt <= '0;
        else if (i_clr)
            o_special_cnt <= '0;
        else if (out_xfer && (s2_sel != SEL_NORMAL) && (o_special_cnt != '1))
            o_special_cnt <= o_special_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_fpu_psc_pipe.sv
// Directed bench for fpu_psc_pipe; counter narrowed to 4 bits so saturation is reachable.
module tb_fpu_psc_pipe;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [1:0]    i_op;
    logic          i_sign_a, i_sign_b;
    logic [7:0]    i_exp_a, i_exp_b;
    logic [23:0]   i_man_a, i_man_b;
    logic [3:0]    i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [2:0]    o_sel;
    logic          o_sign;
    logic [3:0]    o_tag;
    logic          i_clr;
    logic          o_flag_invalid;
    logic          o_flag_nan_in;
    logic [CW-1:0] o_special_cnt;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    always #5 i_clk = ~i_clk;

    fpu_psc_pipe #(.CNT_W(CW)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_op           (i_op),
        .i_sign_a       (i_sign_a),
        .i_sign_b       (i_sign_b),
        .i_exp_a        (i_exp_a),
        .i_exp_b        (i_exp_b),
        .i_man_a        (i_man_a),
        .i_man_b        (i_man_b),
        .i_tag          (i_tag),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_sel          (o_sel),
        .o_sign         (o_sign),
        .o_tag          (o_tag),
        .i_clr          (i_clr),
        .o_flag_invalid (o_flag_invalid),
        .o_flag_nan_in  (o_flag_nan_in),
        .o_special_cnt  (o_special_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [32:0] a, input logic [32:0] b,
                         input logic [3:0] tg);
        i_op     = op;
        i_sign_a = a[32];
        i_exp_a  = a[31:24];
        i_man_a  = a[23:0];
        i_sign_b = b[32];
        i_exp_b  = b[31:24];
        i_man_b  = b[23:0];
        i_tag    = tg;
    endtask

    task automatic bump_cnt(input logic [2:0] sel);
        if (sel != 3'b000 && exp_cnt < CNT_MAX)
            exp_cnt++;
    endtask

    // Single transfer with i_ready high: 2-cycle latency, then drained.
    task automatic run_vec(input string nm, input logic [1:0] op, input logic [32:0] a,
                           input logic [32:0] b, input logic [3:0] tg,
                           input logic [2:0] esel, input logic esign);
        drive(op, a, b, tg);
        i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc();
        chk({nm, "_vld"}, o_valid, 1);
        chk({nm, "_sel"}, o_sel, esel);
        chk({nm, "_sign"}, o_sign, esign);
        chk({nm, "_tag"}, o_tag, tg);
        cyc();
        bump_cnt(esel);
        chk({nm, "_cnt"}, o_special_cnt, exp_cnt);
        chk({nm, "_drain"}, o_valid, 0);
    endtask

    initial begin
        int       sent, rcvd, infl, cn;
        logic     held, in_x, out_x;
        logic [2:0] h_sel;
        logic       h_sign;
        logic [3:0] h_tag;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_clr   = 1'b0;
        drive(2'b00, 33'h0, 33'h0, 4'h0);
        repeat (3) cyc();
        chk("rst_vld", o_valid, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_sign", o_sign, 0);
        chk("rst_tag", o_tag, 0);
        chk("rst_cnt", o_special_cnt, 0);
        chk("rst_inv", o_flag_invalid, 0);
        chk("rst_nan", o_flag_nan_in, 0);
        i_rst_n = 1'b1;
        #1;
        chk("rst_ready", o_ready, 1);

        run_vec("mul_inf_zero", 2'b00, {1'b0, 8'hFF, 24'h800000}, {1'b1, 8'h00, 24'h0}, 4'h1, 3'b011, 1'b0);
        chk("mul_inf_zero_inv", o_flag_invalid, 1);
        chk("mul_inf_zero_nan", o_flag_nan_in, 0);

        i_clr = 1'b1;
        cyc();
        i_clr = 1'b0;
        exp_cnt = 0;
        chk("clr_inv", o_flag_invalid, 0);
        chk("clr_cnt", o_special_cnt, 0);

        run_vec("add_pass_a", 2'b01, {1'b0, 8'h80, 24'hC00000}, {1'b1, 8'h00, 24'h000123}, 4'h2, 3'b100, 1'b0);
        chk("add_pass_a_inv", o_flag_invalid, 0);
        run_vec("sub_inf_inf", 2'b10, {1'b0, 8'hFF, 24'h800000}, {1'b0, 8'hFF, 24'h800000}, 4'h3, 3'b011, 1'b0);
        chk("sub_inf_inf_inv", o_flag_invalid, 1);
        run_vec("add_nz_nz", 2'b01, {1'b1, 8'h00, 24'h0}, {1'b1, 8'h00, 24'h0}, 4'h4, 3'b001, 1'b1);
        run_vec("sub_nz_nz", 2'b10, {1'b1, 8'h00, 24'h0}, {1'b1, 8'h00, 24'h0}, 4'h5, 3'b001, 1'b0);
        run_vec("mul_norm", 2'b00, {1'b1, 8'h80, 24'hC00000}, {1'b0, 8'h7F, 24'h800000}, 4'h6, 3'b000, 1'b1);
        run_vec("add_nan", 2'b01, {1'b0, 8'hFF, 24'hC00000}, {1'b0, 8'h80, 24'h800000}, 4'h7, 3'b011, 1'b0);
        chk("add_nan_flag", o_flag_nan_in, 1);
        run_vec("add_b_inf", 2'b01, {1'b0, 8'h81, 24'h800000}, {1'b1, 8'hFF, 24'h800000}, 4'h8, 3'b010, 1'b1);
        run_vec("sub_pass_b", 2'b10, {1'b0, 8'h00, 24'h0}, {1'b1, 8'h81, 24'h900000}, 4'h9, 3'b101, 1'b0);
        run_vec("rsvd_as_mul", 2'b11, {1'b1, 8'hFF, 24'h800000}, {1'b1, 8'h81, 24'h800000}, 4'hA, 3'b010, 1'b0);
        run_vec("mul_dnz_inf", 2'b00, {1'b0, 8'h00, 24'h000005}, {1'b0, 8'hFF, 24'h800000}, 4'hB, 3'b011, 1'b0);
        run_vec("add_pinf_ninf", 2'b01, {1'b0, 8'hFF, 24'h800000}, {1'b1, 8'hFF, 24'h800000}, 4'hC, 3'b011, 1'b0);
        run_vec("add_normal", 2'b01, {1'b1, 8'h80, 24'h800000}, {1'b0, 8'h80, 24'h800000}, 4'hD, 3'b000, 1'b0);

        // Stream of 8 tagged pairs, downstream stalled during cycles 3..5.
        sent = 0; rcvd = 0; infl = 0; cn = 0; held = 1'b0;
        h_sel = 3'b000; h_sign = 1'b0; h_tag = 4'h0;
        while (rcvd < 8 && cn < 60) begin
            i_ready = !(cn >= 3 && cn <= 5);
            if (sent < 8) begin
                if (sent % 2 == 0)
                    drive(2'b00, {1'b0, 8'h85, 24'hA00000}, {1'b1, 8'h00, 24'h0}, 4'(sent));
                else
                    drive(2'b01, {1'b0, 8'h85, 24'hA00000}, {1'b0, 8'h84, 24'h900000}, 4'(sent));
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            chk("stream_ready", o_ready, (i_ready || infl < 2));
            if (held) begin
                chk("stall_vld", o_valid, 1);
                chk("stall_sel", o_sel, h_sel);
                chk("stall_sign", o_sign, h_sign);
                chk("stall_tag", o_tag, h_tag);
            end
            in_x  = i_valid & o_ready;
            out_x = o_valid & i_ready;
            if (out_x) begin
                chk("stream_tag", o_tag, rcvd);
                chk("stream_sel", o_sel, (rcvd % 2 == 0) ? 3'b001 : 3'b000);
                chk("stream_sign", o_sign, (rcvd % 2 == 0) ? 1'b1 : 1'b0);
                bump_cnt((rcvd % 2 == 0) ? 3'b001 : 3'b000);
                rcvd++;
            end
            held   = o_valid & ~i_ready;
            h_sel  = o_sel;
            h_sign = o_sign;
            h_tag  = o_tag;
            cyc();
            if (in_x) begin
                sent++;
                infl++;
            end
            if (out_x)
                infl--;
            cn++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stream_done", rcvd, 8);
        chk("stream_sent", sent, 8);
        #1;
        chk("stream_empty", o_valid, 0);
        chk("stream_cnt", o_special_cnt, exp_cnt);

        for (int k = 0; k < 4; k++)
            run_vec("sat", 2'b00, {1'b0, 8'hFF, 24'h800000}, {1'b0, 8'h80, 24'h800000}, 4'(k), 3'b010, 1'b0);
        chk("sat_max", o_special_cnt, CNT_MAX);

        // Clear in the same cycle as a NaN input, then in the same cycle as a special delivery.
        drive(2'b01, {1'b0, 8'hFF, 24'h800001}, {1'b0, 8'h80, 24'h800000}, 4'h3);
        i_valid = 1'b1;
        i_clr   = 1'b1;
        cyc();
        i_valid = 1'b0;
        i_clr   = 1'b0;
        exp_cnt = 0;
        chk("clrnan_nan", o_flag_nan_in, 0);
        chk("clrnan_inv", o_flag_invalid, 0);
        chk("clrnan_cnt", o_special_cnt, 0);
        cyc();
        chk("clrnan_vld", o_valid, 1);
        chk("clrnan_sel", o_sel, 3'b011);
        i_clr = 1'b1;
        cyc();
        i_clr = 1'b0;
        chk("clrout_cnt", o_special_cnt, 0);
        chk("clrout_drain", o_valid, 0);

        // Reset with two entries in flight.
        drive(2'b00, {1'b0, 8'hFF, 24'h800000}, {1'b0, 8'h80, 24'h800000}, 4'h1);
        i_valid = 1'b1;
        cyc();
        drive(2'b00, {1'b0, 8'h00, 24'h0}, {1'b0, 8'h80, 24'h800000}, 4'h2);
        cyc();
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        chk("inflight_vld", o_valid, 1);
        chk("inflight_ready", o_ready, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_vld", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_sel", o_sel, 0);
        chk("midrst_tag", o_tag, 0);
        chk("midrst_cnt", o_special_cnt, 0);
        cyc();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("postrst_vld", o_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
